// File: rtl/line_arbiter3_if.sv
// rtl/line_arbiter3_if.sv - requester and memory-port signal bundle for line_arbiter3
// slave: arbiter side; master: requesters plus lower-level memory.
interface line_arbiter3_if;
    logic         dcache_read;
    logic         dcache_write;
    logic [31:0]  dcache_address;
    logic [255:0] dcache_wdata;
    logic         dcache_resp;
    logic [255:0] dcache_rdata;

    logic         icache_read;
    logic [31:0]  icache_address;
    logic         icache_resp;
    logic [255:0] icache_rdata;

    logic         pf_read;
    logic [31:0]  pf_address;
    logic         pf_resp;
    logic [255:0] pf_rdata;

    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata;
    logic         mem_resp;
    logic [255:0] mem_rdata;

    modport slave (
        input  dcache_read, dcache_write, dcache_address, dcache_wdata,
        output dcache_resp, dcache_rdata,
        input  icache_read, icache_address,
        output icache_resp, icache_rdata,
        input  pf_read, pf_address,
        output pf_resp, pf_rdata,
        output mem_read, mem_write, mem_address, mem_wdata,
        input  mem_resp, mem_rdata
    );

    modport master (
        output dcache_read, dcache_write, dcache_address, dcache_wdata,
        input  dcache_resp, dcache_rdata,
        output icache_read, icache_address,
        input  icache_resp, icache_rdata,
        output pf_read, pf_address,
        input  pf_resp, pf_rdata,
        input  mem_read, mem_write, mem_address, mem_wdata,
        output mem_resp, mem_rdata
    );
endinterface

// File: rtl/line_arbiter3.sv
// rtl/line_arbiter3.sv - D-cache / I-cache / prefetcher cacheline arbiter for one 256-bit memory port
// Optional ARB_ROUND_ROBIN_EN: round-robin between D-cache and I-cache instead of fixed D > I.
module line_arbiter3 #(
    parameter int PF_AGE_LIMIT = 15
) (
    input logic            clk,
    input logic            reset_n,
    line_arbiter3_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        GNT_D,
        GNT_I,
        GNT_PF,
        RELEASE
    } state_t;

    localparam logic [3:0] AGE_LIMIT = 4'(PF_AGE_LIMIT);

    state_t     state_q, state_d;
    logic [3:0] pf_age_q, pf_age_d;

    logic d_req;
    logic i_req;
    logic p_req;
    logic pf_aged;

`ifdef ARB_ROUND_ROBIN_EN
    // 0: D-cache was granted last, 1: I-cache was granted last
    logic last_gnt_q, last_gnt_d;
`endif

    assign d_req   = bus.dcache_read | bus.dcache_write;
    assign i_req   = bus.icache_read;
    assign p_req   = bus.pf_read;
    assign pf_aged = p_req && (pf_age_q == AGE_LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            pf_age_q <= 4'd0;
`ifdef ARB_ROUND_ROBIN_EN
            last_gnt_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pf_age_q <= pf_age_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_gnt_q <= last_gnt_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        pf_age_d = pf_age_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_gnt_d = last_gnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pf_aged) begin
                    state_d = GNT_PF;
                end else if (d_req && i_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                    state_d = last_gnt_q ? GNT_D : GNT_I;
`else
                    state_d = GNT_D;
`endif
                end else if (d_req) begin
                    state_d = GNT_D;
                end else if (i_req) begin
                    state_d = GNT_I;
                end else if (p_req) begin
                    state_d = GNT_PF;
                end

                // The prefetcher only ages while it is actually losing arbitrations.
                if (!p_req || state_d == GNT_PF) begin
                    pf_age_d = 4'd0;
                end else if (state_d == GNT_D || state_d == GNT_I) begin
                    pf_age_d = (pf_age_q >= AGE_LIMIT) ? AGE_LIMIT : pf_age_q + 4'd1;
                end

`ifdef ARB_ROUND_ROBIN_EN
                if (state_d == GNT_D) begin
                    last_gnt_d = 1'b0;
                end else if (state_d == GNT_I) begin
                    last_gnt_d = 1'b1;
                end
`endif
            end
            GNT_D, GNT_I, GNT_PF: begin
                if (bus.mem_resp) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Forwarding is purely combinational from the registered grant, so an
    // asynchronous reset drops the downstream request immediately.
    always_comb begin
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_address = 32'd0;
        bus.mem_wdata   = 256'd0;
        bus.dcache_resp = 1'b0;
        bus.icache_resp = 1'b0;
        bus.pf_resp     = 1'b0;
        case (state_q)
            GNT_D: begin
                bus.mem_read    = bus.dcache_read;
                bus.mem_write   = bus.dcache_write;
                bus.mem_address = bus.dcache_address;
                bus.mem_wdata   = bus.dcache_wdata;
                bus.dcache_resp = bus.mem_resp;
            end
            GNT_I: begin
                // Read-only requesters keep the read asserted for the whole grant.
                bus.mem_read    = 1'b1;
                bus.mem_address = bus.icache_address;
                bus.icache_resp = bus.mem_resp;
            end
            GNT_PF: begin
                bus.mem_read    = 1'b1;
                bus.mem_address = bus.pf_address;
                bus.pf_resp     = bus.mem_resp;
            end
            default: begin
            end
        endcase
    end

    assign bus.dcache_rdata = bus.mem_rdata;
    assign bus.icache_rdata = bus.mem_rdata;
    assign bus.pf_rdata     = bus.mem_rdata;

endmodule

// File: tb/tb_line_arbiter3.sv
// tb/tb_line_arbiter3.sv - self-checking bench for line_arbiter3
module tb_line_arbiter3;
    localparam int AGE_LIM = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    line_arbiter3_if bus();

    line_arbiter3 #(.PF_AGE_LIMIT(AGE_LIM)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic         d;
        logic         i;
        logic         p;
        logic [255:0] rdata;
    } resp_t;

    typedef struct {
        logic [1:0]   who;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] rdata;
    } vec_t;

    int    n_vec = 0;
    int    n_err = 0;
    resp_t sb_q[$];
    vec_t  vecs[6];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs;
        bus.dcache_read  = 1'b0;
        bus.dcache_write = 1'b0;
        bus.icache_read  = 1'b0;
        bus.pf_read      = 1'b0;
    endtask

    task automatic clear_all;
        clear_reqs();
        bus.dcache_address = 32'd0;
        bus.dcache_wdata   = 256'd0;
        bus.icache_address = 32'd0;
        bus.pf_address     = 32'd0;
        bus.mem_resp       = 1'b0;
        bus.mem_rdata      = 256'd0;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        clear_all();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic push_exp(input logic d, input logic i, input logic p, input logic [255:0] rd);
        resp_t e;
        e.d = d;
        e.i = i;
        e.p = p;
        e.rdata = rd;
        sb_q.push_back(e);
    endtask

    task automatic grant_chk(input logic rd, input logic wr, input logic [31:0] addr, input logic [255:0] wd);
        chk("mem_read", 256'(bus.mem_read), 256'(rd));
        chk("mem_write", 256'(bus.mem_write), 256'(wr));
        chk("mem_address", 256'(bus.mem_address), 256'(addr));
        chk("mem_wdata", bus.mem_wdata, wd);
    endtask

    // Called at a negedge while granted: pulses mem_resp, scores the resp lines, returns at posedge+1.
    task automatic complete(input logic [255:0] rd);
        resp_t e;
        bus.mem_rdata = rd;
        bus.mem_resp  = 1'b1;
        #1;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_empty: got a completion with no expected entry");
        end else begin
            e = sb_q.pop_front();
            chk("dcache_resp", 256'(bus.dcache_resp), 256'(e.d));
            chk("icache_resp", 256'(bus.icache_resp), 256'(e.i));
            chk("pf_resp", 256'(bus.pf_resp), 256'(e.p));
            if (e.d) chk("dcache_rdata", bus.dcache_rdata, e.rdata);
            if (e.i) chk("icache_rdata", bus.icache_rdata, e.rdata);
            if (e.p) chk("pf_rdata", bus.pf_rdata, e.rdata);
        end
        tick();
        bus.mem_resp = 1'b0;
    endtask

    task automatic wait_fwd(input int max_cyc, output int waited);
        waited = 0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            waited++;
            if (bus.mem_read || bus.mem_write) break;
        end
        chk("fwd_seen", 256'(bus.mem_read | bus.mem_write), 256'(1));
    endtask

    task automatic run_vec(input vec_t v);
        logic is_d;
        is_d = (v.who == 2'd0);
        bus.dcache_wdata = v.wdata;
        case (v.who)
            2'd0: begin
                bus.dcache_read    = ~v.wr;
                bus.dcache_write   = v.wr;
                bus.dcache_address = v.addr;
            end
            2'd1: begin
                bus.icache_read    = 1'b1;
                bus.icache_address = v.addr;
            end
            default: begin
                bus.pf_read    = 1'b1;
                bus.pf_address = v.addr;
            end
        endcase
        push_exp(is_d, v.who == 2'd1, v.who == 2'd2, v.rdata);
        @(negedge clk);
        chk("idle_no_fwd", 256'({bus.mem_read, bus.mem_write}), 256'(0));
        @(negedge clk);
        grant_chk(~(is_d & v.wr), is_d & v.wr, v.addr, is_d ? v.wdata : 256'd0);
        complete(v.rdata);
        clear_reqs();
        @(negedge clk);
        chk("release_quiet", 256'({bus.mem_read, bus.mem_write}), 256'(0));
        chk("release_addr", 256'(bus.mem_address), 256'(0));
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int waited;
        logic [255:0] w_line;
        logic [255:0] r_line;

        vecs[0] = '{who: 2'd1, wr: 1'b0, addr: 32'h0000_0060, wdata: {8{32'h1111_2222}}, rdata: {32{8'hA5}}};
        vecs[1] = '{who: 2'd0, wr: 1'b0, addr: 32'h0000_1000, wdata: {8{32'h3333_4444}}, rdata: {8{32'hDEAD_BEEF}}};
        vecs[2] = '{who: 2'd0, wr: 1'b1, addr: 32'h0000_2040, wdata: {4{64'h0123_4567_89AB_CDEF}}, rdata: 256'd0};
        vecs[3] = '{who: 2'd2, wr: 1'b0, addr: 32'h0000_3000, wdata: {8{32'h5555_6666}}, rdata: {16{16'h5A5A}}};
        vecs[4] = '{who: 2'd1, wr: 1'b0, addr: 32'hFFFF_FFE0, wdata: {8{32'h7777_8888}}, rdata: {256{1'b1}}};
        vecs[5] = '{who: 2'd0, wr: 1'b1, addr: 32'h0000_0000, wdata: {256{1'b1}}, rdata: {8{$urandom}}};

        clear_all();
        // reset asserted mid-grant, with the prefetcher already aged once
        do_reset();
        bus.dcache_read    = 1'b1;
        bus.dcache_address = 32'h0000_0440;
        bus.pf_read        = 1'b1;
        bus.pf_address     = 32'h0000_0880;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre_grant", 256'(bus.mem_address), 256'(32'h0000_0440));
        chk("rst_pre_age", 256'(dut.pf_age_q), 256'(1));
        bus.mem_resp = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("rst_mem_read", 256'(bus.mem_read), 256'(0));
        chk("rst_mem_addr", 256'(bus.mem_address), 256'(0));
        chk("rst_no_resp", 256'({bus.dcache_resp, bus.icache_resp, bus.pf_resp}), 256'(0));
        clear_all();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        chk("rst_age", 256'(dut.pf_age_q), 256'(0));
        run_vec(vecs[0]);

        for (int k = 0; k < 6; k++) run_vec(vecs[k]);

        // simultaneous D-write and I-read
        do_reset();
        w_line = {8{32'hCAFE_F00D}};
        bus.dcache_write   = 1'b1;
        bus.dcache_address = 32'h0000_0100;
        bus.dcache_wdata   = w_line;
        bus.icache_read    = 1'b1;
        bus.icache_address = 32'h0000_0200;
`ifdef ARB_ROUND_ROBIN_EN
        push_exp(1'b0, 1'b1, 1'b0, {8{32'h0000_0002}});
        push_exp(1'b1, 1'b0, 1'b0, {8{32'h0000_0001}});
        @(negedge clk);
        @(negedge clk);
        grant_chk(1'b1, 1'b0, 32'h0000_0200, 256'd0);
        complete({8{32'h0000_0002}});
        bus.icache_read = 1'b0;
        @(negedge clk);
        chk("sim_gap1", 256'({bus.mem_read, bus.mem_write}), 256'(0));
        @(negedge clk);
        chk("sim_gap2", 256'({bus.mem_read, bus.mem_write}), 256'(0));
        @(negedge clk);
        grant_chk(1'b0, 1'b1, 32'h0000_0100, w_line);
        complete({8{32'h0000_0001}});
        bus.dcache_write = 1'b0;
`else
        push_exp(1'b1, 1'b0, 1'b0, {8{32'h0000_0001}});
        push_exp(1'b0, 1'b1, 1'b0, {8{32'h0000_0002}});
        @(negedge clk);
        @(negedge clk);
        grant_chk(1'b0, 1'b1, 32'h0000_0100, w_line);
        complete({8{32'h0000_0001}});
        bus.dcache_write = 1'b0;
        @(negedge clk);
        chk("sim_gap1", 256'({bus.mem_read, bus.mem_write}), 256'(0));
        @(negedge clk);
        chk("sim_gap2", 256'({bus.mem_read, bus.mem_write}), 256'(0));
        @(negedge clk);
        grant_chk(1'b1, 1'b0, 32'h0000_0200, 256'd0);
        complete({8{32'h0000_0002}});
        bus.icache_read = 1'b0;
`endif
        @(negedge clk);
        tick();

        // prefetcher starvation: D-cache requests back-to-back
        do_reset();
        bus.dcache_read    = 1'b1;
        bus.dcache_address = 32'h0000_0500;
        bus.pf_read        = 1'b1;
        bus.pf_address     = 32'h0000_0900;
        for (int k = 1; k <= AGE_LIM + 1; k++) begin
            wait_fwd(8, waited);
            chk("b2b_gap", 256'(waited), 256'((k == 1) ? 2 : 3));
            r_line = {8{32'(k)}};
            if (k <= AGE_LIM) begin
                chk("starve_addr_d", 256'(bus.mem_address), 256'(32'h0000_0500));
                chk("starve_age", 256'(dut.pf_age_q), 256'(k));
                push_exp(1'b1, 1'b0, 1'b0, r_line);
            end else begin
                chk("starve_addr_pf", 256'(bus.mem_address), 256'(32'h0000_0900));
                chk("starve_age_clr", 256'(dut.pf_age_q), 256'(0));
                push_exp(1'b0, 1'b0, 1'b1, r_line);
            end
            complete(r_line);
            if (k == AGE_LIM + 1) clear_reqs();
        end
        @(negedge clk);
        tick();

        // stray mem_resp in IDLE
        bus.mem_resp = 1'b1;
        @(negedge clk);
        chk("idle_resp_ignored", 256'({bus.dcache_resp, bus.icache_resp, bus.pf_resp}), 256'(0));
        chk("idle_resp_mem", 256'({bus.mem_read, bus.mem_write}), 256'(0));
        tick();
        bus.mem_resp = 1'b0;
        run_vec(vecs[1]);

        // I-cache drops its request mid-grant; stray mem_resp held into RELEASE
        bus.icache_read    = 1'b1;
        bus.icache_address = 32'h0000_07C0;
        push_exp(1'b0, 1'b1, 1'b0, {4{64'hFEED_FACE_0BAD_F00D}});
        @(negedge clk);
        @(negedge clk);
        chk("drop_grant", 256'(bus.mem_read), 256'(1));
        bus.icache_read = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("drop_hold", 256'(bus.mem_read), 256'(1));
            chk("drop_addr", 256'(bus.mem_address), 256'(32'h0000_07C0));
        end
        complete({4{64'hFEED_FACE_0BAD_F00D}});
        bus.mem_resp = 1'b1;
        @(negedge clk);
        chk("rel_resp_ignored", 256'({bus.dcache_resp, bus.icache_resp, bus.pf_resp}), 256'(0));
        chk("rel_mem", 256'({bus.mem_read, bus.mem_write}), 256'(0));
        tick();
        bus.mem_resp = 1'b0;
        @(negedge clk);
        chk("post_drop_idle", 256'({bus.mem_read, bus.mem_write}), 256'(0));
        tick();
        run_vec(vecs[3]);

        chk("sb_drain", 256'(sb_q.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
